// File: rtl/dev_bus_ctrl.sv
// rtl/dev_bus_ctrl.sv - CPU-to-peripheral bus controller with wait states and masked interrupt arbiter
// Optional bus-error capture: define DEV_BUSERR_EN.
module dev_bus_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F00,
  parameter int          WAIT_CYCLES = 1,
  parameter int          NUM_DEV     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [3:0]  dev_sel,
  output logic [1:0]  dev_add,
  output logic        dev_we,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  input  logic [31:0] dev_rdata2,
  input  logic [31:0] dev_rdata3,
  input  logic [3:0]  dev_irq,
  output logic        irq_out,
  output logic [1:0]  irq_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [31:0] MASK_ADDR = BASE_ADDR + 32'h40;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h44;
  localparam logic [3:0]  DEV_VALID = 4'((1 << NUM_DEV) - 1);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic        lat_we;
  logic [3:0]  irq_mask;
  logic [3:0]  irq_raw;
  logic [3:0]  pend;
  logic [1:0]  dev_idx;
  logic        dev_hit, mask_hit, stat_hit, eaddr_hit;
  logic        last_cycle;
  logic [31:0] stat_word;
  logic [31:0] rd_mux;
  logic        err_flag;

  // Address decode on the latched request
  assign dev_idx    = lat_addr[5:4];
  assign dev_hit    = (lat_addr[31:6] == BASE_ADDR[31:6]) && DEV_VALID[dev_idx];
  assign mask_hit   = (lat_addr == MASK_ADDR);
  assign stat_hit   = (lat_addr == STAT_ADDR);
  assign last_cycle = (state == ACCESS) && (cnt == 4'd0);
  assign irq_raw    = dev_irq & DEV_VALID;
  assign pend       = irq_raw & irq_mask;
  assign stat_word  = {24'd0, err_flag, irq_out, irq_id, irq_raw};

`ifdef DEV_BUSERR_EN
  localparam logic [31:0] EADDR_ADDR = BASE_ADDR + 32'h48;
  logic [31:0] err_addr;
  logic        unmapped;
  assign eaddr_hit = (lat_addr == EADDR_ADDR);
  assign unmapped  = !(dev_hit || mask_hit || stat_hit || eaddr_hit);

  // Sticky error flag; address capture only while the flag is clear, read of IRQ_STAT clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_addr <= 32'd0;
    end else if (last_cycle) begin
      if (unmapped) begin
        err_flag <= 1'b1;
        if (!err_flag) err_addr <= lat_addr;
      end else if (stat_hit && !lat_we) begin
        err_flag <= 1'b0;
      end
    end
  end
`else
  logic [31:0] err_addr;
  assign eaddr_hit = 1'b0;
  assign err_flag  = 1'b0;
  assign err_addr  = 32'd0;
`endif

  // Read data source for the completing access; unmapped reads return zero
  always_comb begin
    rd_mux = 32'd0;
    if (dev_hit) begin
      case (dev_idx)
        2'd0:    rd_mux = dev_rdata0;
        2'd1:    rd_mux = dev_rdata1;
        2'd2:    rd_mux = dev_rdata2;
        default: rd_mux = dev_rdata3;
      endcase
    end else if (mask_hit) begin
      rd_mux = {28'd0, irq_mask};
    end else if (stat_hit) begin
      rd_mux = stat_word;
    end else if (eaddr_hit) begin
      rd_mux = err_addr;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    state_nx  = state;
    dev_sel   = 4'd0;
    dev_we    = 1'b0;
    cpu_ready = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nx = ACCESS;
      end
      ACCESS: begin
        if (dev_hit) dev_sel = 4'b0001 << dev_idx;
        if (cnt == 4'd0) begin
          dev_we   = lat_we && dev_hit;
          state_nx = DONE;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, request latches, wait counter, read data and mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_we    <= 1'b0;
      dev_wdata <= 32'd0;
      dev_add   <= 2'd0;
      cpu_rdata <= 32'd0;
      irq_mask  <= 4'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu_req) begin
        lat_addr  <= cpu_addr;
        lat_we    <= cpu_we;
        dev_wdata <= cpu_wdata;
        dev_add   <= cpu_addr[3:2];
        cnt       <= WAIT_INIT;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (last_cycle) begin
        if (!lat_we) cpu_rdata <= rd_mux;
        else if (mask_hit) irq_mask <= dev_wdata[3:0];
      end
    end
  end

  // Fixed-priority interrupt arbiter, device 0 highest; a bus error claims id 3
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_out <= 1'b0;
      irq_id  <= 2'd0;
    end else begin
      irq_out <= (|pend) || err_flag;
      if (pend[0])      irq_id <= 2'd0;
      else if (pend[1]) irq_id <= 2'd1;
      else if (pend[2]) irq_id <= 2'd2;
      else if (pend[3] || err_flag) irq_id <= 2'd3;
      else              irq_id <= 2'd0;
    end
  end

endmodule

// File: tb/tb_dev_bus_ctrl.sv
// tb/tb_dev_bus_ctrl.sv - directed table-driven bench for dev_bus_ctrl
module tb_dev_bus_ctrl;
  localparam int          WAIT = 1;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [3:0]  dev_sel;
  logic [1:0]  dev_add;
  logic        dev_we;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata0 = 32'hCAFE_0001;
  logic [31:0] dev_rdata1 = 32'h1111_2222;
  logic [31:0] dev_rdata2 = 32'h3333_4444;
  logic [31:0] dev_rdata3 = 32'h5555_6666;
  logic [3:0]  dev_irq = 4'b1111;
  logic        irq_out;
  logic [1:0]  irq_id;

  int n_cmp = 0;
  int n_err = 0;

  dev_bus_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT), .NUM_DEV(4)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .dev_sel(dev_sel), .dev_add(dev_add),
    .dev_we(dev_we), .dev_wdata(dev_wdata), .dev_rdata0(dev_rdata0),
    .dev_rdata1(dev_rdata1), .dev_rdata2(dev_rdata2), .dev_rdata3(dev_rdata3),
    .dev_irq(dev_irq), .irq_out(irq_out), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_add;
    int          exp_we;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction from a negedge; inputs are scrambled after acceptance
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic [3:0] sel_seen, output int sel_cycles,
                     output int we_pulses, output logic [31:0] we_data,
                     output int ready_at, output int ready_cnt);
    rd = 32'hX; sel_seen = 4'd0; sel_cycles = 0; we_pulses = 0; we_data = 32'd0;
    ready_at = -1; ready_cnt = 0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = 32'hDEAD_BEE0; cpu_wdata = 32'hBAD0_BAD0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (dev_sel != 4'd0) begin sel_cycles++; sel_seen = dev_sel; end
      if (dev_we) begin we_pulses++; we_data = dev_wdata; end
      if (cpu_ready) begin
        ready_cnt++;
        if (ready_at < 0) begin ready_at = k; rd = cpu_rdata; end
      end
    end
  endtask

  logic [31:0] rd, wd;
  logic [3:0]  ss;
  int          sc, wp, ra, rc;
  int          t_first, t_second, pulses;
  logic [31:0] exp_stat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, BASE + 32'h00, 32'h0,         32'hCAFE_0001, 4'b0001, 2'd0, 0};
    vecs[1] = '{1'b1, BASE + 32'h1C, 32'h55,        32'hCAFE_0001, 4'b0010, 2'd3, 1};
    vecs[2] = '{1'b0, BASE + 32'h24, 32'h0,         32'h3333_4444, 4'b0100, 2'd1, 0};
    vecs[3] = '{1'b0, BASE + 32'h3C, 32'h0,         32'h5555_6666, 4'b1000, 2'd3, 0};
    vecs[4] = '{1'b1, BASE + 32'h40, 32'hFFFF_FFF6, 32'h5555_6666, 4'b0000, 2'd0, 0};
    vecs[5] = '{1'b0, BASE + 32'h40, 32'h0,         32'h0000_0006, 4'b0000, 2'd0, 0};
    vecs[6] = '{1'b0, BASE + 32'h80, 32'h0,         32'h0000_0000, 4'b0000, 2'd0, 0};
    vecs[7] = '{1'b1, BASE + 32'h84, 32'h1234_5678, 32'h0000_0000, 4'b0000, 2'd1, 0};
`ifdef DEV_BUSERR_EN
    vecs[8] = '{1'b0, BASE + 32'h48, 32'h0,         BASE + 32'h80, 4'b0000, 2'd2, 0};
`else
    vecs[8] = '{1'b0, BASE + 32'h48, 32'h0,         32'h0000_0000, 4'b0000, 2'd2, 0};
`endif

    // Reset state
    #12;
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_sel", 32'(dev_sel), 32'd0);
    check("rst_we", 32'(dev_we), 32'd0);
    check("rst_add", 32'(dev_add), 32'd0);
    check("rst_wdata", dev_wdata, 32'd0);
    check("rst_irq_out", 32'(irq_out), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Mask resets to zero: all-pending devices stay silent
    @(negedge clk); @(negedge clk);
    check("mask0_irq_out", 32'(irq_out), 32'd0);
    check("mask0_irq_id", 32'(irq_id), 32'd0);
    dev_irq = 4'b0000;

    // Table-driven single transactions
    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, ss, sc, wp, wd, ra, rc);
      check($sformatf("v%0d_rdata", i), (vecs[i].we ? cpu_rdata : rd), vecs[i].exp_rdata);
      check($sformatf("v%0d_sel", i), 32'(ss), 32'(vecs[i].exp_sel));
      check($sformatf("v%0d_sel_cycles", i), 32'(sc), (vecs[i].exp_sel != 4'd0) ? 32'(WAIT + 1) : 32'd0);
      check($sformatf("v%0d_add", i), 32'(dev_add), 32'(vecs[i].exp_add));
      check($sformatf("v%0d_we_pulses", i), 32'(wp), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we != 0) check($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
      check($sformatf("v%0d_ready_at", i), 32'(ra), 32'(WAIT + 2));
      check($sformatf("v%0d_ready_cnt", i), 32'(rc), 32'd1);
    end

`ifdef DEV_BUSERR_EN
    check("err_irq_out", 32'(irq_out), 32'd1);
    check("err_irq_id", 32'(irq_id), 32'd3);
    exp_stat = 32'h0000_00ED;
`else
    check("noerr_irq_out", 32'(irq_out), 32'd0);
    exp_stat = 32'h0000_006D;
`endif

    // Masked arbitration: mask 0110, irq 1101 -> device 2
    dev_irq = 4'b1101;
    @(negedge clk); @(negedge clk);
    check("arb_irq_out", 32'(irq_out), 32'd1);
    check("arb_irq_id", 32'(irq_id), 32'd2);
    txn(1'b0, BASE + 32'h44, 32'h0, rd, ss, sc, wp, wd, ra, rc);
    check("stat_read1", rd, exp_stat);
    txn(1'b0, BASE + 32'h44, 32'h0, rd, ss, sc, wp, wd, ra, rc);
    check("stat_read2", rd, 32'h0000_006D);
    txn(1'b1, BASE + 32'h44, 32'hFFFF_FFFF, rd, ss, sc, wp, wd, ra, rc);
    check("stat_write_ignored_mask", 32'(irq_out), 32'd1);

    // Mask write reaches irq_out one cycle after the write edge
    cpu_we = 1'b1; cpu_addr = BASE + 32'h40; cpu_wdata = 32'd0; cpu_req = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    ra = -1;
    for (int k = 1; k <= 8 && ra < 0; k++) begin
      @(negedge clk);
      if (cpu_ready) ra = k;
    end
    check("maskwr_ready_at", 32'(ra), 32'(WAIT + 2));
    check("maskwr_irq_at_done", 32'(irq_out), 32'd1);
    @(negedge clk);
    check("maskwr_irq_after", 32'(irq_out), 32'd0);
    check("maskwr_id_after", 32'(irq_id), 32'd0);

    // Back-to-back with cpu_req held high
    cpu_we = 1'b0; cpu_addr = BASE + 32'h20; cpu_req = 1'b1;
    t_first = -1; t_second = -1; pulses = 0;
    for (int k = 1; k <= 20 && t_second < 0; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        pulses++;
        if (t_first < 0) t_first = k; else t_second = k;
        check($sformatf("b2b_rdata%0d", pulses), cpu_rdata, 32'h3333_4444);
      end
    end
    cpu_req = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_gap", 32'(t_second - t_first), 32'(WAIT + 3));
    @(negedge clk); @(negedge clk);

    // Reset in the middle of a device write
    cpu_we = 1'b1; cpu_addr = BASE + 32'h10; cpu_wdata = 32'h77; cpu_req = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    check("mid_sel_before", 32'(dev_sel), 32'b0010);
    #1 reset = 1'b1;
    #1;
    check("mid_sel", 32'(dev_sel), 32'd0);
    check("mid_ready", 32'(cpu_ready), 32'd0);
    check("mid_rdata", cpu_rdata, 32'd0);
    check("mid_wdata", dev_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wp = 0; rc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dev_we) wp++;
      if (cpu_ready) rc++;
    end
    check("mid_no_we", 32'(wp), 32'd0);
    check("mid_no_ready", 32'(rc), 32'd0);
    txn(1'b0, BASE + 32'h00, 32'h0, rd, ss, sc, wp, wd, ra, rc);
    check("recover_rdata", rd, 32'hCAFE_0001);
    check("recover_sel", 32'(ss), 32'b0001);
    check("recover_ready_at", 32'(ra), 32'(WAIT + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dev_bus_ctrl.md
Name: dev_bus_ctrl

Overview:
Memory-mapped bus controller between the CPU data port and up to four simple peripherals (input device, output device, timers). Peripherals use a 2-bit register select on address bits [3:2].
- Decodes the CPU address into a one-hot device select.
- Sequences each access through a fixed wait-state window.
- Returns registered read data with a one-cycle ready pulse.
- Arbitrates peripheral interrupt lines by fixed priority under a software mask.

Parameters:
BASE_ADDR, 32'h0000_7F00, base of the peripheral window; bits [5:0] must be zero.
WAIT_CYCLES, 1, extra ACCESS cycles per transaction (0..15).
NUM_DEV, 4, number of attached devices (1..4); unused select/irq lines tie off to 0.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  access request, level; sampled only in IDLE
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data
cpu_rdata  output  32  registered read data, valid while cpu_ready=1
cpu_ready  output  1  one-cycle completion pulse
dev_sel  output  4  one-hot device select, held for the whole ACCESS state
dev_add  output  2  register select, latched cpu_addr[3:2]
dev_we  output  1  write strobe, one cycle, last ACCESS cycle only
dev_wdata  output  32  latched write data
dev_rdata0..dev_rdata3  input  32 each  device read data
dev_irq  input  4  device interrupt requests, level
irq_out  output  1  registered CPU interrupt
irq_id  output  2  registered index of the highest-priority pending unmasked device

Behaviour:
Reset state:
- Reset is asynchronous and active-high. It forces state IDLE.
- All outputs go to 0. irq_mask goes to 4'b0000 (all interrupts disabled). Internal latches clear.
- Reset in mid-transaction aborts it: no ready pulse and no write strobe.

Address decode (on the latched address):
- Device window: BASE_ADDR..BASE_ADDR+0x3F. Device index = addr[5:4]. An index >= NUM_DEV counts as unmapped.
- Controller registers:
  - BASE_ADDR+0x40 = IRQ_MASK: bits [3:0] R/W, upper bits read 0.
  - BASE_ADDR+0x44 = IRQ_STAT: read-only. Bits [3:0] = raw dev_irq. Bits [5:4] = irq_id. Bit 6 = irq_out. Bit 7 = bus error flag (optional feature). Writes to IRQ_STAT are ignored.
- Any other address is unmapped.

State machine:
- IDLE: when cpu_req=1, latch addr, we and wdata, load cnt=WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - dev_sel is driven for device hits. Controller-register and unmapped accesses drive dev_sel=0.
  - When cnt!=0: decrement cnt and stay in ACCESS.
  - When cnt==0: assert dev_we=latched we (device hits only), capture read data into cpu_rdata at the clock edge, go to DONE.
  - Writes to IRQ_MASK also take effect at this edge.
- DONE: cpu_ready=1 for exactly one cycle, dev_sel=0, go to IDLE.

Timing and data rules:
- Latency: request accepted at edge E, cpu_ready high in the cycle after edge E+WAIT_CYCLES+1 (3 cycles from request at WAIT_CYCLES=1).
- cpu_req is ignored outside IDLE. Back-to-back requests therefore see one IDLE cycle between ready and the next acceptance.
- Changes to the cpu_* inputs after acceptance have no effect.
- cpu_rdata holds its value until the next read completes.
- On a write, cpu_rdata is unchanged.
- On an unmapped read, cpu_rdata = 0. An unmapped write is dropped.

Interrupts:
- Evaluated every cycle, registered.
- pend = dev_irq & irq_mask. irq_out = |pend.
- irq_id = lowest set index of pend (device 0 highest priority), or 0 when pend==0.
- A mask write affects irq_out on the cycle after the write edge.

Optional Feature:
Macro: DEV_BUSERR_EN.
Defined:
- An unmapped access sets a sticky error flag (IRQ_STAT bit 7) and latches the offending address.
- The latched address is readable at BASE_ADDR+0x48. It holds the first error only until the flag is cleared.
- A read of IRQ_STAT returns the flag and clears it at the same completion edge.
- While the flag is set, irq_out is forced to 1 and irq_id to 2'b11 unless a higher-priority unmasked device is pending.
Not defined:
- No flag and no 0x48 register; reads of 0x48 return 0.
- IRQ_STAT bit 7 reads 0. Unmapped accesses are silent.

Test Plan:
- Reset mid-ACCESS (write to device 1 at WAIT_CYCLES=1) -> dev_sel=0, dev_we never pulses, no cpu_ready, next transaction completes normally.
- Read BASE+0x00 with dev_rdata0=32'hCAFE_0001, WAIT_CYCLES=1 -> dev_sel=4'b0001 for 2 cycles, dev_add=0, cpu_ready one pulse 3 cycles after request, cpu_rdata=32'hCAFE_0001.
- Write 32'h55 to BASE+0x1C -> dev_sel=4'b0010, dev_add=2'b11, single dev_we pulse on last ACCESS cycle with dev_wdata=32'h55.
- Write IRQ_MASK=4'b0110, then drive dev_irq=4'b1101 -> irq_out=1, irq_id=2; read IRQ_STAT -> 32'h0000_006D.
- Mask=0 with dev_irq=4'b1111 -> irq_out=0; hold cpu_req high for two transactions -> exactly one IDLE cycle between ready pulses.
- Read BASE+0x80 (unmapped) -> cpu_rdata=0, ready pulse. With DEV_BUSERR_EN: IRQ_STAT bit 7=1 on next read then cleared, 0x48 reads BASE+0x80.
